// File: rtl/inv_kin_arbiter.sv
// rtl/inv_kin_arbiter.sv - round-robin arbiter/sequencer sharing one inv_kin datapath
module inv_kin_arbiter #(
  parameter int BIT_WIDTH     = 32,
  parameter int SETTLE_CYCLES = 500,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic                   req1_valid,
  output logic                   req0_ready,
  output logic                   req1_ready,
  input  logic [BIT_WIDTH-1:0]   req0_x,
  input  logic [BIT_WIDTH-1:0]   req0_y,
  input  logic [BIT_WIDTH-1:0]   req1_x,
  input  logic [BIT_WIDTH-1:0]   req1_y,
  output logic [BIT_WIDTH-1:0]   ik_x,
  output logic [BIT_WIDTH-1:0]   ik_y,
  input  logic [BIT_WIDTH-1:0]   ik_theta1,
  input  logic [BIT_WIDTH-1:0]   ik_theta2,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [BIT_WIDTH-1:0]   rsp_theta1,
  output logic [BIT_WIDTH-1:0]   rsp_theta2,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] jobs_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // Counter only has to hold SETTLE_CYCLES-1; keep at least one bit for SETTLE_CYCLES=1.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]   ik_x_q, ik_x_d;
  logic [BIT_WIDTH-1:0]   ik_y_q, ik_y_d;
  logic                   id_q, id_d;
  logic                   prio_q, prio_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BIT_WIDTH-1:0]   th1_q, th1_d;
  logic [BIT_WIDTH-1:0]   th2_q, th2_d;
  logic [COUNT_WIDTH-1:0] jobs_q, jobs_d;

  logic idle;
  logic req_any;
  logic prio_valid;
  logic grant;

  // Round-robin grant: favoured requester if valid, otherwise the other one.
  always_comb begin
    idle       = (state_q == S_IDLE);
    req_any    = req0_valid | req1_valid;
    prio_valid = prio_q ? req1_valid : req0_valid;
    grant      = prio_valid ? prio_q : ~prio_q;
    req0_ready = idle && req_any && !grant;
    req1_ready = idle && req_any && grant;
  end

  // Next-state logic for the accept / settle / respond sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ik_x_d      = ik_x_q;
    ik_y_d      = ik_y_q;
    id_d        = id_q;
    prio_d      = prio_q;
    rsp_valid_d = rsp_valid_q;
    th1_d       = th1_q;
    th2_d       = th2_q;
    jobs_d      = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          ik_x_d  = grant ? req1_x : req0_x;
          ik_y_d  = grant ? req1_y : req0_y;
          id_d    = grant;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Only the final settle cycle's thetas are trusted.
        if (cnt_q == '0) begin
          th1_d       = ik_theta1;
          th2_d       = ik_theta2;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          prio_d      = ~id_q;
          jobs_d      = jobs_q + COUNT_WIDTH'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any job in flight and wins over handshakes.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ik_x_q      <= '0;
      ik_y_q      <= '0;
      id_q        <= 1'b0;
      prio_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      th1_q       <= '0;
      th2_q       <= '0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ik_x_q      <= ik_x_d;
      ik_y_q      <= ik_y_d;
      id_q        <= id_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      th1_q       <= th1_d;
      th2_q       <= th2_d;
      jobs_q      <= jobs_d;
    end
  end

  assign ik_x       = ik_x_q;
  assign ik_y       = ik_y_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_theta1 = th1_q;
  assign rsp_theta2 = th2_q;
  assign busy       = (state_q != S_IDLE);
  assign jobs_done  = jobs_q;

endmodule
